ofdm_payload_sched: RTL and testbench

Frame-level controller that sequences ofdm_payload_gen. It collects a byte stream into a one-symbol buffer of NSC words, then bursts each symbol into the generator as one contiguous in_data_en window. It waits for the generator's out_done before starting the next symbol, and pads a short final symbol. It sits between the MAC-side byte source and ofdm_payload_gen.

---
 rtl/ofdm_payload_sched.sv | 219 +++++++++++++++++++++
 tb/tb_ofdm_payload_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_payload_sched.sv
// Frame scheduler for ofdm_payload_gen: buffers a symbol of source words, bursts it, then waits for out_done.
// Define OFDM_PAYLOAD_SCHED_PINGPONG_EN for a second buffer that fills while the other symbol is sent.
module ofdm_payload_sched #(
    parameter int unsigned NSC          = 48,
    parameter int unsigned SYM_CNT_W    = 10,
    parameter logic [7:0]  PAD_VALUE    = 8'h00,
    parameter int unsigned DONE_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [SYM_CNT_W-1:0] num_sym,
    input  logic [2:0]           modulation,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 pg_data_en,
    output logic [7:0]           pg_data,
    output logic [2:0]           pg_modulation,
    input  logic                 pg_done,
    output logic                 busy,
    output logic [SYM_CNT_W-1:0] sym_idx,
    output logic                 frame_done,
    output logic                 err_timeout
);

`ifdef OFDM_PAYLOAD_SCHED_PINGPONG_EN
    localparam int unsigned NBUF = 2;
`else
    localparam int unsigned NBUF = 1;
`endif
    localparam int unsigned IW = (NSC > 1) ? $clog2(NSC) : 1;
    localparam int unsigned CW = $clog2(NSC + 1);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FILL, BURST, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [NBUF][NSC];
    logic [NBUF-1:0]      full_q, full_d;
    logic [CW-1:0]        lvl_q [NBUF];
    logic [CW-1:0]        lvl_d [NBUF];
    logic                 wb_q, wb_d, rb_q, rb_d;
    logic [IW-1:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic                 pad_q, pad_d;
    logic [SYM_CNT_W-1:0] fsym_q, fsym_d, nsym_q, nsym_d, sym_idx_q, sym_idx_d;
    logic [2:0]           mod_q, mod_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 err_q, err_d, frame_done_q, frame_done_d;
    logic                 pg_data_en_q, pg_data_en_d;
    logic [7:0]           pg_data_q, pg_data_d;
    logic                 wr_room, wr_en, fill_done, nwb, nrb;

    // A buffer is writable while it is not holding a completed symbol and the frame still needs symbols.
    assign wr_room = (state_q != IDLE) && !full_q[wb_q] && (fsym_q < nsym_q);
    assign s_ready = wr_room && !pad_q;
    assign nwb     = (NBUF > 1) ? ~wb_q : wb_q;
    assign nrb     = (NBUF > 1) ? ~rb_q : rb_q;

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        lvl_d        = lvl_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        pad_d        = pad_q;
        fsym_d       = fsym_q;
        nsym_d       = nsym_q;
        sym_idx_d    = sym_idx_q;
        mod_d        = mod_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        pg_data_en_d = 1'b0;
        pg_data_d    = '0;
        wr_en        = 1'b0;
        fill_done    = 1'b0;

        // Writer: after the source ended, each remaining symbol completes empty and reads as padding.
        if (wr_room && pad_q) begin
            fill_done    = 1'b1;
            lvl_d[wb_q]  = '0;
        end else if (s_ready && s_valid) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
            if (s_last) begin
                pad_d = 1'b1;
            end
            if (s_last || (wcnt_q == IW'(NSC - 1))) begin
                fill_done   = 1'b1;
                lvl_d[wb_q] = CW'(wcnt_q) + 1'b1;
            end
        end
        if (fill_done) begin
            full_d[wb_q] = 1'b1;
            wcnt_d       = '0;
            fsym_d       = fsym_q + 1'b1;
            wb_d         = nwb;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    nsym_d    = (num_sym == '0) ? SYM_CNT_W'(1) : num_sym;
                    mod_d     = modulation;
                    sym_idx_d = '0;
                    wcnt_d    = '0;
                    rcnt_d    = '0;
                    wb_d      = 1'b0;
                    rb_d      = 1'b0;
                    full_d    = '0;
                    pad_d     = 1'b0;
                    fsym_d    = '0;
                    err_d     = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (full_q[rb_q] || (fill_done && (wb_q == rb_q))) begin
                    rcnt_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                pg_data_en_d = 1'b1;
                pg_data_d    = (CW'(rcnt_q) < lvl_q[rb_q]) ? mem_q[rb_q][rcnt_q] : PAD_VALUE;
                rcnt_d       = rcnt_q + 1'b1;
                if (rcnt_q == IW'(NSC - 1)) begin
                    rcnt_d  = '0;
                    tmo_d   = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pg_done) begin
                    full_d[rb_q] = 1'b0;
                    rb_d         = nrb;
                    if (sym_idx_q == nsym_q - 1'b1) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        sym_idx_d = sym_idx_q + 1'b1;
                        // Only the alternate buffer can already hold the next symbol.
                        if ((NBUF > 1) && (full_q[nrb] || (fill_done && (wb_q == nrb)))) begin
                            state_d = BURST;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            full_q       <= '0;
            lvl_q        <= '{default: '0};
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            pad_q        <= 1'b0;
            fsym_q       <= '0;
            nsym_q       <= '0;
            sym_idx_q    <= '0;
            mod_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            pg_data_en_q <= 1'b0;
            pg_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            lvl_q        <= lvl_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            pad_q        <= pad_d;
            fsym_q       <= fsym_d;
            nsym_q       <= nsym_d;
            sym_idx_q    <= sym_idx_d;
            mod_q        <= mod_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            pg_data_en_q <= pg_data_en_d;
            pg_data_q    <= pg_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wb_q][wcnt_q] <= s_data;
        end
    end

    assign busy          = (state_q != IDLE);
    assign sym_idx       = sym_idx_q;
    assign pg_modulation = mod_q;
    assign frame_done    = frame_done_q;
    assign err_timeout   = err_q;
    assign pg_data_en    = pg_data_en_q;
    assign pg_data       = pg_data_q;

endmodule

// File: tb/tb_ofdm_payload_sched.sv
// Scoreboard bench for ofdm_payload_sched: expected generator words are queued as the source is driven
// and popped on every pg_data_en cycle; frame-level behaviour is checked per scenario task.
module tb_ofdm_payload_sched;
    localparam int NSC       = 48;
    localparam int SYM_CNT_W = 10;
    localparam int TMO       = 1023;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic [SYM_CNT_W-1:0] num_sym = '0;
    logic [2:0]           modulation = '0;
    logic                 s_valid = 1'b0;
    logic [7:0]           s_data = '0;
    logic                 s_last = 1'b0;
    logic                 s_ready;
    logic                 pg_data_en;
    logic [7:0]           pg_data;
    logic [2:0]           pg_modulation;
    logic                 pg_done = 1'b0;
    logic                 busy;
    logic [SYM_CNT_W-1:0] sym_idx;
    logic                 frame_done;
    logic                 err_timeout;

    ofdm_payload_sched #(
        .NSC(NSC),
        .SYM_CNT_W(SYM_CNT_W),
        .PAD_VALUE(8'h00),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .num_sym(num_sym),
        .modulation(modulation),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .pg_data_en(pg_data_en),
        .pg_data(pg_data),
        .pg_modulation(pg_modulation),
        .pg_done(pg_done),
        .busy(busy),
        .sym_idx(sym_idx),
        .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         sym_log[$];
    logic [2:0] exp_mod = '0;
    int         run_len = 0;
    int         bursts = 0;
    int         fd_cnt = 0;
    int         fd_cyc = -1;
    int         first_en_cyc = -1;
    int         last_en_cyc = -1;
    int         last_hs_cyc = -1;
    int         done_timer = -1;
    int         done_delay = 5;
    int         done_set_cyc = -1;
    bit         auto_done = 1'b1;
    bit         sready_watch = 1'b0;
    int         sready_bad = 0;

    // Advance one clock, sample outputs 1 ns after the edge, run the scoreboard and the pg_done responder.
    task automatic cycle();
        logic [7:0] exp_w;
        @(posedge clk);
        #1;
        cyc++;
        if (pg_data_en === 1'b1) begin
            if (run_len == 0) begin
                sym_log.push_back(int'(sym_idx));
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            run_len++;
            last_en_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pg_data_extra: got %02h, required no word", pg_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (pg_data !== exp_w) begin
                    errors++;
                    $display("FAIL pg_data: got %02h, required %02h (cycle %0d)", pg_data, exp_w, cyc);
                end
            end
            vectors++;
            if (pg_modulation !== exp_mod) begin
                errors++;
                $display("FAIL pg_modulation: got %0d, required %0d", pg_modulation, exp_mod);
            end
        end else if (run_len != 0) begin
            vectors++;
            if (run_len != NSC) begin
                errors++;
                $display("FAIL burst_len: got %0d, required %0d", run_len, NSC);
            end
            bursts++;
            run_len = 0;
            if (auto_done) done_timer = done_delay;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (sready_watch && (s_ready !== 1'b0)) sready_bad++;
        pg_done = 1'b0;
        if (done_timer == 0) begin
            pg_done      = 1'b1;
            done_set_cyc = cyc;
            done_timer   = -1;
        end else if (done_timer > 0) begin
            done_timer--;
        end
    endtask

    task automatic start_frame(input int n, input logic [2:0] mod);
        num_sym      = n[SYM_CNT_W-1:0];
        modulation   = mod;
        exp_mod      = mod;
        start        = 1'b1;
        bursts       = 0;
        fd_cnt       = 0;
        fd_cyc       = -1;
        first_en_cyc = -1;
        sready_bad   = 0;
        sready_watch = 1'b0;
        sym_log.delete();
        cycle();
        start = 1'b0;
    endtask

    // Stream nw words base, base+1, ... with s_last on the final one; inject_at>=0 pulses start and pg_done once.
    task automatic feed(input int nw, input logic [7:0] base, input int nsym_eff, input int inject_at);
        int i = 0;
        int budget = 0;
        bit hs;
        bit injected = 1'b0;
        while (i < nw && budget < 4000) begin
            if (i == inject_at && !injected) begin
                s_valid    = 1'b0;
                start      = 1'b1;
                num_sym    = 10'd5;
                modulation = 3'd1;
                pg_done    = 1'b1;
                cycle();
                start    = 1'b0;
                injected = 1'b1;
            end
            s_valid = 1'b1;
            s_data  = base + i[7:0];
            s_last  = (i == nw - 1);
            hs      = (s_ready === 1'b1);
            if (hs) last_hs_cyc = cyc;
            cycle();
            budget++;
            if (hs) begin
                exp_q.push_back(s_data);
                if (s_last) begin
                    for (int k = nw; k < nsym_eff * NSC; k++) exp_q.push_back(8'h00);
                end
                i++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        vectors++;
        if (i != nw) begin
            errors++;
            $display("FAIL feed_accept: got %0d words accepted, required %0d", i, nw);
        end
        sready_watch = 1'b1;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        sready_watch = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        vectors++;
        if ({s_ready, pg_data_en, busy, frame_done, err_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %05b, required 00000", {s_ready, pg_data_en, busy, frame_done, err_timeout});
        end
        vectors++;
        if ({pg_data, pg_modulation, sym_idx} !== '0) begin
            errors++;
            $display("FAIL reset_buses: got data=%02h mod=%0d sym=%0d, required all 0", pg_data, pg_modulation, sym_idx);
        end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_symbol();
        done_delay = 20;
        start_frame(1, 3'd4);
        feed(48, 8'h00, 1, -1);
        wait_frame(300);
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_left: got %0d words unsent, required 0", exp_q.size()); end
        vectors++;
        if (bursts != 1) begin errors++; $display("FAIL single_bursts: got %0d, required 1", bursts); end
        vectors++;
        if (fd_cnt != 1) begin errors++; $display("FAIL single_frame_done: got %0d pulses, required 1", fd_cnt); end
        vectors++;
        if (first_en_cyc - last_hs_cyc != 2) begin
            errors++;
            $display("FAIL fill_to_burst_latency: got %0d, required 2", first_en_cyc - last_hs_cyc);
        end
        vectors++;
        if (fd_cyc != done_set_cyc + 1) begin
            errors++;
            $display("FAIL done_to_frame_done: got %0d, required %0d", fd_cyc, done_set_cyc + 1);
        end
        vectors++;
        if (busy !== 1'b0 || pg_modulation !== 3'd4) begin
            errors++;
            $display("FAIL single_idle: got busy=%b mod=%0d, required busy=0 mod=4", busy, pg_modulation);
        end
        done_delay = 5;
        start_frame(0, 3'd2);
        feed(48, 8'h80, 1, -1);
        wait_frame(300);
        vectors++;
        if (bursts != 1 || fd_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL num_sym_zero: got bursts=%0d pulses=%0d left=%0d, required 1 1 0", bursts, fd_cnt, exp_q.size());
        end
    endtask

    task automatic test_padded_tail();
        start_frame(2, 3'd2);
        feed(60, 8'h01, 2, -1);
        wait_frame(500);
        vectors++;
        if (exp_q.size() != 0 || bursts != 2 || fd_cnt != 1) begin
            errors++;
            $display("FAIL pad_tail: got left=%0d bursts=%0d pulses=%0d, required 0 2 1", exp_q.size(), bursts, fd_cnt);
        end
        vectors++;
        if (sym_log.size() != 2) begin
            errors++;
            $display("FAIL pad_tail_symlog: got %0d entries, required 2", sym_log.size());
        end else if (sym_log[0] != 0 || sym_log[1] != 1) begin
            errors++;
            $display("FAIL pad_tail_sym_idx: got %0d,%0d, required 0,1", sym_log[0], sym_log[1]);
        end
    endtask

    task automatic test_short_frame();
        start_frame(3, 3'd5);
        feed(10, 8'hA0, 3, -1);
        wait_frame(700);
        vectors++;
        if (exp_q.size() != 0 || bursts != 3 || fd_cnt != 1) begin
            errors++;
            $display("FAIL short_frame: got left=%0d bursts=%0d pulses=%0d, required 0 3 1", exp_q.size(), bursts, fd_cnt);
        end
        vectors++;
        if (sready_bad != 0) begin
            errors++;
            $display("FAIL short_sready: got %0d cycles with s_ready high, required 0", sready_bad);
        end
        vectors++;
        if (sym_log.size() != 3 || sym_log[sym_log.size() - 1] != 2) begin
            errors++;
            $display("FAIL short_sym_idx: got %0d bursts logged, required 3 ending at index 2", sym_log.size());
        end
    endtask

    task automatic test_timeout();
        auto_done = 1'b0;
        start_frame(1, 3'd1);
        feed(48, 8'h10, 1, -1);
        wait_frame(TMO + 200);
        vectors++;
        if (fd_cnt != 1) begin errors++; $display("FAIL timeout_frame_done: got %0d pulses, required 1", fd_cnt); end
        vectors++;
        if (fd_cyc - last_en_cyc != TMO) begin
            errors++;
            $display("FAIL timeout_delay: got %0d, required %0d", fd_cyc - last_en_cyc, TMO);
        end
        vectors++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: got err=%b busy=%b, required err=1 busy=0", err_timeout, busy);
        end
        auto_done = 1'b1;
        start_frame(1, 3'd1);
        vectors++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, required 0", err_timeout); end
        feed(48, 8'h50, 1, -1);
        wait_frame(300);
        vectors++;
        if (fd_cnt != 1 || bursts != 1 || err_timeout !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover: got pulses=%0d bursts=%0d err=%b left=%0d, required 1 1 0 0",
                     fd_cnt, bursts, err_timeout, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        start_frame(1, 3'd6);
        feed(48, 8'h20, 1, -1);
        while (run_len < 20 && n < 100) begin
            cycle();
            n++;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pg_data_en, busy, s_ready, frame_done} !== 4'b0 || pg_modulation !== 3'd0 || run_len != 20) begin
            errors++;
            $display("FAIL reset_mid_burst: got en=%b busy=%b rdy=%b fd=%b mod=%0d word=%0d, required 0 0 0 0 0 20",
                     pg_data_en, busy, s_ready, frame_done, pg_modulation, run_len);
        end
        exp_q.delete();
        run_len      = 0;
        sready_watch = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        start_frame(1, 3'd6);
        feed(48, 8'h60, 1, -1);
        wait_frame(300);
        vectors++;
        if (exp_q.size() != 0 || bursts != 1 || fd_cnt != 1) begin
            errors++;
            $display("FAIL reset_recover: got left=%0d bursts=%0d pulses=%0d, required 0 1 1", exp_q.size(), bursts, fd_cnt);
        end
    endtask

    task automatic test_back_to_back_ignored();
        start_frame(2, 3'd7);
        feed(70, 8'h30, 2, 20);
        wait_frame(500);
        vectors++;
        if (exp_q.size() != 0 || bursts != 2 || fd_cnt != 1) begin
            errors++;
            $display("FAIL ignored_inputs: got left=%0d bursts=%0d pulses=%0d, required 0 2 1", exp_q.size(), bursts, fd_cnt);
        end
        vectors++;
        if (pg_modulation !== 3'd7) begin
            errors++;
            $display("FAIL ignored_modulation: got %0d, required 7", pg_modulation);
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_padded_tail();
        test_short_frame();
        test_timeout();
        test_reset_mid_burst();
        test_back_to_back_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
